// File: rtl/scr1_imem_arb2_pkg.sv
// Shared imem protocol encodings and arbiter state type.
package scr1_memif_pkg;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'b00,
    RESP_OKAY  = 2'b01,
    RESP_ERROR = 2'b10
  } resp_e;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/scr1_imem_arb2_if.sv
// One imem-protocol link: req/req_ack request phase plus in-order resp/rdata.
interface scr1_imem_arb2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic              req_ack;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        resp;

  modport master (output req, cmd, addr, input  req_ack, rdata, resp);
  modport slave  (input  req, cmd, addr, output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_arb_id_fifo.sv
// Master-ID FIFO for outstanding imem transactions; push/pop take effect on the clock edge.
// Caller never pushes when full nor pops when empty; count is the live occupancy.
module scr1_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_id,
  input  logic                       pop,
  output logic                       head_id,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       mem <= '0;
    else if (push) mem[wr_ptr] <= push_id;
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/scr1_imem_arb2.sv
// Round-robin arbiter of two imem masters onto one router port; request and response paths are combinational.
// A stalled request freezes the grant until acked; requests are withheld while OUTST_DEPTH transactions are outstanding.
module scr1_imem_arb2
  import scr1_memif_pkg::*;
#(
  parameter int OUTST_DEPTH = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  scr1_imem_arb2_if.slave                  m0,
  scr1_imem_arb2_if.slave                  m1,
  scr1_imem_arb2_if.master                 s,
  output logic [$clog2(OUTST_DEPTH+1)-1:0] outst_cnt,
  output logic                             err_unexp_resp
);
  arb_state_e        state;
  arb_state_e        state_nxt;
  logic              hold_id;
  logic              last_grant;
  logic              grant;
  logic              grant_vld;
  logic              s_req_w;
  logic [ADDR_W-1:0] s_addr_w;
  logic [DATA_W-1:0] m0_rdata_w;
  logic [DATA_W-1:0] m1_rdata_w;
  logic              push;
  logic              pop;
  logic              resp_vld;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_vld = 1'b0;
    case (state)
      ST_ARB: begin
        if (m0.req && m1.req) begin
          grant     = ~last_grant;
          grant_vld = 1'b1;
        end else if (m0.req) begin
          grant_vld = 1'b1;
        end else if (m1.req) begin
          grant     = 1'b1;
          grant_vld = 1'b1;
        end
      end
      ST_HOLD: begin
        grant     = hold_id;
        grant_vld = hold_id ? m1.req : m0.req;
      end
      default: ;
    endcase

    // Reset gating keeps the router quiet even though the FIFO reads as empty.
    s_req_w = grant_vld & ~fifo_full & ~rst;
    if (state == ST_ARB && s_req_w && !s.req_ack) state_nxt = ST_HOLD;
    if (state == ST_HOLD && s_req_w && s.req_ack) state_nxt = ST_ARB;

    s_addr_w  = '0;
    s.cmd     = CMD_RD;
    if (grant_vld) begin
      s_addr_w = grant ? m1.addr : m0.addr;
      s.cmd    = grant ? m1.cmd  : m0.cmd;
    end
    s.req      = s_req_w;
    s.addr     = s_addr_w;
    push       = s_req_w & s.req_ack;
    m0.req_ack = push & ~grant;
    m1.req_ack = push & grant;

    resp_vld   = (s.resp != RESP_IDLE);
    pop        = resp_vld & ~fifo_empty & ~rst;
    m0.resp    = RESP_IDLE;
    m1.resp    = RESP_IDLE;
    m0_rdata_w = '0;
    m1_rdata_w = '0;
    if (pop && !head_id) begin
      m0.resp    = s.resp;
      m0_rdata_w = s.rdata;
    end
    if (pop && head_id) begin
      m1.resp    = s.resp;
      m1_rdata_w = s.rdata;
    end
    m0.rdata = m0_rdata_w;
    m1.rdata = m1_rdata_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_id        <= 1'b0;
      last_grant     <= 1'b1;
      err_unexp_resp <= 1'b0;
    end else begin
      if (state == ST_ARB && state_nxt == ST_HOLD) hold_id <= grant;
      if (push) last_grant <= grant;
      if (resp_vld && fifo_empty) err_unexp_resp <= 1'b1;
    end
  end

  scr1_arb_id_fifo #(.DEPTH(OUTST_DEPTH)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (grant),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outst_cnt)
  );
endmodule

// File: doc/scr1_imem_arb2.md
Name: scr1_imem_arb2

Overview:
- Two-requester arbiter for the SCR1 instruction-memory interface, between two imem-protocol masters and the single imem port of the AHB router (i_imem_ahb).
- Master 0 is core fetch; master 1 is the debug/program-loader path.
- Request phase is req/req_ack. Response phase is in-order: resp 2'b00 IDLE, 2'b01 OKAY, 2'b10 ERROR.
- An ID FIFO tracks outstanding transactions so each response returns to the master that issued it.

Parameters:
- OUTST_DEPTH, 2, maximum outstanding acked-but-unanswered transactions (power of 2, ≥1).
- ADDR_W, 32, address width.
- DATA_W, 32, read-data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  master 0 request.
- m0_cmd  in  1  master 0 command (0 read, 1 write).
- m0_addr  in  ADDR_W  master 0 address.
- m0_req_ack  out  1  master 0 request accepted.
- m0_rdata  out  DATA_W  master 0 read data.
- m0_resp  out  2  master 0 response.
- m1_req, m1_cmd, m1_addr, m1_req_ack, m1_rdata, m1_resp: same as master 0, for master 1.
- s_req  out  1  request to imem router.
- s_cmd  out  1  command to router.
- s_addr  out  ADDR_W  address to router.
- s_req_ack  in  1  router accepted request.
- s_rdata  in  DATA_W  router read data.
- s_resp  in  2  router response.
- outst_cnt  out  $clog2(OUTST_DEPTH+1)  outstanding transaction count.
- err_unexp_resp  out  1  sticky: non-IDLE s_resp arrived with an empty FIFO.

Behaviour:
- Reset (async, rst=1) clears:
  - FIFO pointers; outst_cnt=0.
  - state=ARB; last_grant=1, so master 0 wins first.
  - err_unexp_resp=0.
- While rst=1: s_req=0, m*_req_ack=0, m*_resp=IDLE, m*_rdata=0.
- Transactions outstanding when reset asserts are dropped; their later responses are not routed.
- FSM:
  - ARB: grant chosen combinationally.
    - Only one m*_req high: that master.
    - Both high: the master other than last_grant (round-robin).
  - HOLD: grant frozen to the registered hold_id.
  - ARB→HOLD when s_req=1 and s_req_ack=0 (register hold_id).
  - HOLD→ARB on s_req&s_req_ack.
  - Guarantees s_addr/s_cmd stay stable until acked. The master must keep its req high until ack (protocol rule; not checked).
- Forwarding:
  - s_req = granted m*_req & !fifo_full.
  - s_addr/s_cmd mux from the granted master; zero when no grant.
  - Granted m*_req_ack = s_req_ack & s_req; the other master's ack = 0.
  - Request path latency 0 cycles (combinational).
- Push on s_req&s_req_ack: write grant ID to FIFO tail; last_grant ← grant.
- Pop on s_resp != IDLE with FIFO non-empty: head ID selects destination.
  - That master receives s_resp/s_rdata combinationally; the other sees IDLE and rdata 0.
- Simultaneous push and pop: outst_cnt unchanged; pointers both advance.
- Full (outst_cnt==OUTST_DEPTH):
  - s_req=0 and no acks. A pop in the same cycle does not unblock; push is allowed next cycle.
  - HOLD cannot occur while full, since s_req=0.
- Non-IDLE s_resp with an empty FIFO: no pop; both m*_resp IDLE; err_unexp_resp←1 until reset.
- s_resp=2'b11: treated as ERROR for routing (pops, forwarded unchanged).
- Pointers wrap modulo OUTST_DEPTH. outst_cnt is an up/down counter and never exceeds OUTST_DEPTH.

Decomposition:
- Shared package (scr1_memif_pkg):
  - resp enum (IDLE/OKAY/ERROR).
  - cmd enum (RD/WR).
  - arbiter state enum (ARB/HOLD).
- One sub-module: scr1_arb_id_fifo, a 1-bit-wide FIFO of OUTST_DEPTH entries with push/pop/full/empty/count.

Test Plan:
1. m0_req only, addr 0x200; ack same cycle; next cycle s_resp=OKAY, s_rdata=0x057E4505 → m0_resp=OKAY, m0_rdata=0x057E4505; m1_resp=IDLE; outst_cnt 0→1→0.
2. m0 and m1 request together every cycle, ack always 1 → grants alternate m0, m1, m0, m1; responses return to masters in the same order.
3. m1_req addr 0x400, s_req_ack held 0 for 3 cycles while m0_req rises → s_addr stays 0x400; m1 acked at cycle 4; m0 granted next.
4. DEPTH=2: two acked requests, no responses → third request blocked (s_req=0); one OKAY → request issued the following cycle.
5. s_resp=OKAY with an empty FIFO → err_unexp_resp=1, both m*_resp IDLE; stays 1 until rst.
6. Assert rst with 1 outstanding → all outputs at reset values; post-reset m0 request served normally, outst_cnt=0.
